// File: rtl/updn_seq_pkg.sv
// Shared types and constants for the up3/dn2 command sequencer.
package updn_seq_pkg;

  parameter int REPW = 3;

  typedef struct packed {
    logic rst;
    logic up3;
    logic dn2;
  } cmd_t;

  // Command driven while idle: holds the downstream counter in reset.
  localparam cmd_t IDLE_CMD = 3'b100;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  typedef struct packed {
    cmd_t             cmd;
    logic [REPW-1:0]  rep;
  } entry_t;

endpackage

// File: rtl/updn_seq_mem.sv
// Pattern table: register array with one write port and one combinational read port.
module updn_seq_mem #(
  parameter  int DEPTH = 8,
  parameter  int W     = 6,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Table write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/updn_cmd_seq.sv
// Stimulus sequencer: plays a loaded table of {rst,up3,dn2,rep} entries
// onto the command inputs of the up3/dn2 counter.
module updn_cmd_seq #(
  parameter  int DEPTH = 8,
  parameter  int REPW  = 3,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [3+REPW-1:0] cfg_data,
  input  logic [AW:0]     cfg_len,
  input  logic            start,
  input  logic            stop,
  input  logic            loop,
  output logic            dut_rst,
  output logic            up3,
  output logic            dn2,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   step_idx
);

  import updn_seq_pkg::*;

  state_t          r_state,  w_state_nxt;
  cmd_t            r_cmd,    w_cmd_nxt;
  logic            r_busy,   w_busy_nxt;
  logic            r_done,   w_done_nxt;
  logic [AW-1:0]   r_idx,    w_idx_nxt;
  logic [REPW-1:0] r_rep,    w_rep_nxt;
  logic [AW:0]     r_len,    w_len_nxt;

  logic [AW-1:0]   w_idx_inc;
  logic [AW-1:0]   w_rd_addr;
  logic [3+REPW-1:0] w_rd_data;
  cmd_t            w_rd_cmd;
  logic [REPW-1:0] w_rd_rep;
  logic            w_last;
  logic            w_we;

  // Writes are only accepted while idle so a running pattern cannot be disturbed.
  assign w_we      = cfg_we & (r_state == IDLE);
  assign w_idx_inc = r_idx + AW'(1);
  assign w_last    = ({1'b0, r_idx} == (r_len - (AW+1)'(1)));
  assign w_rd_cmd  = cmd_t'(w_rd_data[3+REPW-1:REPW]);
  assign w_rd_rep  = w_rd_data[REPW-1:0];

  updn_seq_mem #(
    .DEPTH (DEPTH),
    .W     (3+REPW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // Read address pre-selects the entry needed at the next edge: entry 0 when
  // idle (for start) or the following index (with wrap) while playing.
  always_comb begin
    w_rd_addr = '0;
    if (r_state == PLAY) begin
      if (w_last) begin
        w_rd_addr = '0;
      end else begin
        w_rd_addr = w_idx_inc;
      end
    end else begin
      w_rd_addr = '0;
    end
  end

  // Next-state and next-output logic; stop has priority over advance and loop.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_idx_nxt   = r_idx;
    w_rep_nxt   = r_rep;
    w_len_nxt   = r_len;
    case (r_state)
      IDLE: begin
        w_cmd_nxt  = IDLE_CMD;
        w_busy_nxt = 1'b0;
        w_idx_nxt  = '0;
        w_rep_nxt  = '0;
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (start) begin
          if (cfg_len != '0) begin
            w_state_nxt = PLAY;
            w_len_nxt   = cfg_len;
            w_cmd_nxt   = w_rd_cmd;
            w_rep_nxt   = w_rd_rep;
            w_busy_nxt  = 1'b1;
          end else begin
            w_done_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      PLAY: begin
        if (stop) begin
          w_state_nxt = IDLE;
          w_cmd_nxt   = IDLE_CMD;
          w_busy_nxt  = 1'b0;
          w_idx_nxt   = '0;
          w_rep_nxt   = '0;
        end else if (r_rep != '0) begin
          w_rep_nxt = r_rep - REPW'(1);
        end else if (w_last && !loop) begin
          w_state_nxt = IDLE;
          w_cmd_nxt   = IDLE_CMD;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_idx_nxt   = '0;
          w_rep_nxt   = '0;
        end else begin
          w_idx_nxt = w_rd_addr;
          w_cmd_nxt = w_rd_cmd;
          w_rep_nxt = w_rd_rep;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cmd_nxt   = IDLE_CMD;
        w_busy_nxt  = 1'b0;
        w_idx_nxt   = '0;
        w_rep_nxt   = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cmd   <= IDLE_CMD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
      r_rep   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_idx   <= w_idx_nxt;
      r_rep   <= w_rep_nxt;
      r_len   <= w_len_nxt;
    end
  end

  assign dut_rst  = r_cmd.rst;
  assign up3      = r_cmd.up3;
  assign dn2      = r_cmd.dn2;
  assign busy     = r_busy;
  assign done     = r_done;
  assign step_idx = r_idx;

endmodule

// File: doc/updn_cmd_seq.md
Name: updn_cmd_seq

Overview:
Programmable stimulus sequencer that drives the rst/up3/dn2 command inputs of the up-by-3/down-by-2 counter top.
- A small pattern table is loaded through a config write port.
- On start, the table is played out one entry at a time. Each entry is held for a programmable number of cycles, with optional looping.
- It replaces hard-coded per-cycle case stimulus in counter benches and sits directly upstream of the counter.

Parameters:
DEPTH, 8, number of pattern entries (power of 2, >=2)
REPW, 3, width of per-entry repeat field; entry is held for rep+1 cycles
AW, $clog2(DEPTH), table address width (derived, not overridden)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
cfg_we  in  1  table write strobe
cfg_addr  in  AW  table write address
cfg_data  in  3+REPW  {rst,up3,dn2,rep}; command bits in MSBs
cfg_len  in  AW+1  number of entries to play (0..DEPTH), sampled on accepted start
start  in  1  start pulse
stop  in  1  abort playback
loop  in  1  level; sampled at end of last entry
dut_rst  out  1  counter reset command
up3  out  1  counter add-3 command
dn2  out  1  counter subtract-2 command
busy  out  1  high while in PLAY
done  out  1  one-cycle pulse on normal completion
step_idx  out  AW  index of the entry currently driven (0 when idle)

Behaviour:
- Reset (rst_n low at an edge): state IDLE; {dut_rst,up3,dn2}=3'b100; busy=0; done=0; step_idx=0; repeat counter=0. Table contents are not reset. Reset mid-PLAY aborts immediately and sets the same values.
- All outputs are registered. IDLE drives 3'b100, which holds the counter in reset.
- FSM states are IDLE and PLAY.
- IDLE -> PLAY: start=1 and cfg_len!=0 at edge N. cfg_len is latched. In cycle N+1: outputs = entry 0, busy=1, step_idx=0, repeat counter loaded with entry 0 rep.
- start with cfg_len=0: stay IDLE, done=1 in cycle N+1, outputs stay 3'b100.
- In PLAY, each entry is driven for exactly rep+1 consecutive cycles, then the next entry follows with no gap.
- After the last entry (index len-1) completes:
  - loop=1: wrap to entry 0 the next cycle; busy stays 1; no done pulse.
  - loop=0: go to IDLE. The next cycle has outputs 3'b100, busy=0, step_idx=0, and done=1 for one cycle.
- stop=1 in PLAY: next cycle is IDLE with outputs 3'b100 and no done pulse. stop takes priority over entry advance and over the loop decision. stop in IDLE is ignored.
- start while busy is ignored. start and stop in the same IDLE cycle: stop wins, no playback.
- cfg_we while busy is ignored. In IDLE the write takes effect the next edge. A start in the same cycle as a write to entry 0 plays the old entry 0; the write still commits.
- Table read is combinational from the register array. The entry-advance logic pre-reads the next index so that outputs change on the exact boundary cycle.
- Repeat counter is REPW bits; rep = 2^REPW-1 gives a 2^REPW-cycle hold with no overflow.

Decomposition:
- Package updn_seq_pkg holds:
  - cmd_t packed struct {rst,up3,dn2}
  - IDLE_CMD = 3'b100
  - state_t enum {IDLE,PLAY}
  - entry_t packed struct {cmd_t cmd; logic [REPW-1:0] rep}, with REPW as a package parameter default of 3
- Sub-module updn_seq_mem: DEPTH x entry_t register array, with one write port and one combinational read port.
- updn_cmd_seq contains the FSM, index counter and repeat counter.

Test Plan:
1. Load 5 entries {100,010,001,011,000}, all rep=0, len=5, loop=0; pulse start at cycle 0 -> cycles 1..5 drive 100,010,001,011,000; cycle 6 drives 100 with done=1; busy high exactly cycles 1..5.
2. Entry0 = 010 rep=2, entry1 = 001 rep=0, len=2; start -> up3 high for 3 cycles, then dn2 for 1 cycle, then idle with done pulse; step_idx sequence is 0,0,0,1.
3. Same table with loop=1 -> sequence 010x3, 001, 010x3, ... repeats; no done pulse. Deassert loop during entry1 -> sequence ends after that entry, done fires.
4. Table from test 1 with stop asserted in the cycle entry 2 is driven -> next cycle drives 100, busy=0, done stays 0; a subsequent start replays from entry 0.
5. start with cfg_len=0 -> done=1 the next cycle, busy never rises, outputs stay 100. start while busy -> no restart; step_idx keeps advancing normally.
6. rst_n low during entry 3 of test 1 -> next cycle outputs 100, busy=0, done=0. cfg_we during PLAY -> table unchanged on replay.
